// File: rtl/othello_pkg.sv
// Shared board geometry, cell codes and display colours for the othello datapath.
package othello_pkg;

  // Board geometry on the 10x10 sentinel-bordered RAM image.
  localparam int BOARD_W     = 8;
  localparam int ADDR_BASE   = 11;
  localparam int ADDR_STRIDE = 10;
  localparam int RC_W        = $clog2(BOARD_W);

  // Two-bit cell state as stored in the gameboard RAM.
  typedef enum logic [1:0] {
    CELL_EMPTY = 2'b00,
    CELL_P0    = 2'b01,
    CELL_P1    = 2'b10,
    CELL_ERR   = 2'b11
  } cell_e;

  // 3-bit RGB colours used by the renderer.
  localparam logic [2:0] COL_BOARD  = 3'b010;
  localparam logic [2:0] COL_P0     = 3'b000;
  localparam logic [2:0] COL_P1     = 3'b111;
  localparam logic [2:0] COL_ERR    = 3'b100;
  localparam logic [2:0] COL_GRID   = 3'b000;
  localparam logic [2:0] COL_CURSOR = 3'b110;

  // RAM address of a playable cell; the largest value (88) fits in 7 bits.
  function automatic logic [6:0] cell_address(input logic [RC_W-1:0] row,
                                              input logic [RC_W-1:0] col);
    return 7'(ADDR_BASE) + 7'(row) * 7'(ADDR_STRIDE) + 7'(col);
  endfunction

endpackage

// File: rtl/board_renderer_if.sv
// Control, memory-mux and VGA signals of the board renderer.
interface board_renderer_if;
  logic       start;
  logic [6:0] cursor_addr;
  logic       busy_o;
  logic       done_o;
  logic       ctrl_mem;
  logic [6:0] addr_out;
  logic [1:0] data_out;
  logic       wren_o;
  logic [1:0] data_in;
  logic [7:0] x_o;
  logic [6:0] y_o;
  logic [2:0] colour_o;
  logic       plot_o;

  // Controller / memory side.
  modport master (
    output start, cursor_addr, data_in,
    input  busy_o, done_o, ctrl_mem, addr_out, data_out, wren_o,
           x_o, y_o, colour_o, plot_o
  );

  // Renderer side.
  modport slave (
    input  start, cursor_addr, data_in,
    output busy_o, done_o, ctrl_mem, addr_out, data_out, wren_o,
           x_o, y_o, colour_o, plot_o
  );
endinterface

// File: rtl/board_renderer_cell_colour_map.sv
// Maps a cell state and pixel position class to a 3-bit colour.
module cell_colour_map
  import othello_pkg::*;
(
  input  logic [1:0] cell_q,
  input  logic       border,
  input  logic       is_cursor,
  output logic [2:0] colour
);

  // Border pixels show the grid (or cursor); interior pixels show the cell state.
  always_comb begin
    colour = COL_BOARD;
    if (border) begin
      colour = is_cursor ? COL_CURSOR : COL_GRID;
    end else begin
      case (cell_q)
        CELL_EMPTY: colour = COL_BOARD;
        CELL_P0:    colour = COL_P0;
        CELL_P1:    colour = COL_P1;
        default:    colour = COL_ERR;
      endcase
    end
  end

endmodule

// File: rtl/board_renderer.sv
// Walks all playable cells through the memory mux and draws one bordered square per cell.
module board_renderer
  import othello_pkg::*;
#(
  parameter int CELL_PX = 8,
  parameter int X0      = 48,
  parameter int Y0      = 28,
  parameter int RD_LAT  = 2
) (
  input logic            clock,
  input logic            reset,
  board_renderer_if.slave bus
);

  localparam int PXW = $clog2(CELL_PX);
  localparam int WCW = $clog2(RD_LAT + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DRAW  = 3'd3;
  localparam logic [2:0] S_NEXT  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]      state_reg;
  logic [RC_W-1:0] row_reg, col_reg;
  logic [PXW-1:0]  px_reg, py_reg, px_next, py_next;
  logic [WCW-1:0]  wait_reg;
  logic [1:0]      cell_reg, cell_src;
  logic            cursor_reg;
  logic [7:0]      x_reg, x_next;
  logic [6:0]      y_reg, y_next;
  logic [2:0]      colour_reg, colour_next;
  logic            plot_reg, busy_reg, done_reg;
  logic [6:0]      cell_addr;
  logic            ctrl_mem, capture, last_px, last_py, last_col, last_row;
  logic            border, load_pixel;

  assign cell_addr  = cell_address(row_reg, col_reg);
  assign ctrl_mem   = (state_reg == S_FETCH) || (state_reg == S_WAIT);
  assign capture    = (state_reg == S_WAIT) && (wait_reg == WCW'(RD_LAT - 1));
  assign last_px    = (px_reg == PXW'(CELL_PX - 1));
  assign last_py    = (py_reg == PXW'(CELL_PX - 1));
  assign last_col   = (col_reg == RC_W'(BOARD_W - 1));
  assign last_row   = (row_reg == RC_W'(BOARD_W - 1));
  assign load_pixel = capture || ((state_reg == S_DRAW) && !(last_px && last_py));

  // Next pixel to present: (0,0) right after capture, otherwise raster order px-inner.
  always_comb begin
    px_next = px_reg + 1'b1;
    py_next = py_reg;
    if (capture) begin
      px_next = '0;
      py_next = '0;
    end else if (last_px) begin
      px_next = '0;
      py_next = py_reg + 1'b1;
    end
  end

  // The colour of the first pixel must come straight from RAM, since cell_reg loads on the same edge.
  assign cell_src = capture ? bus.data_in : cell_reg;
  assign border   = (px_next == '0) || (py_next == '0);
  // Coordinates computed modulo the output width; identical to a wider sum then truncated.
  assign x_next   = 8'(X0) + (8'(col_reg) << PXW) + 8'(px_next);
  assign y_next   = 7'(Y0) + (7'(row_reg) << PXW) + 7'(py_next);

  cell_colour_map u_colour_map (
    .cell_q    (cell_src),
    .border    (border),
    .is_cursor (cursor_reg),
    .colour    (colour_next)
  );

  // Cell sequencing FSM: fetch, wait for RAM, draw, advance, finish.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      row_reg    <= '0;
      col_reg    <= '0;
      wait_reg   <= '0;
      cell_reg   <= '0;
      cursor_reg <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (bus.start) begin
            row_reg   <= '0;
            col_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= S_FETCH;
          end
        end
        S_FETCH: begin
          cursor_reg <= (bus.cursor_addr == cell_addr);
          wait_reg   <= '0;
          state_reg  <= S_WAIT;
        end
        S_WAIT: begin
          if (capture) begin
            cell_reg  <= bus.data_in;
            state_reg <= S_DRAW;
          end else begin
            wait_reg <= wait_reg + 1'b1;
          end
        end
        S_DRAW: begin
          if (last_px && last_py) state_reg <= S_NEXT;
        end
        S_NEXT: begin
          if (last_col) begin
            col_reg <= '0;
            if (last_row) begin
              row_reg   <= '0;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
              state_reg <= S_DONE;
            end else begin
              row_reg   <= row_reg + 1'b1;
              state_reg <= S_FETCH;
            end
          end else begin
            col_reg   <= col_reg + 1'b1;
            state_reg <= S_FETCH;
          end
        end
        S_DONE:  state_reg <= S_IDLE;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // Registered pixel stream: coordinates, colour and strobe always change together.
  always_ff @(posedge clock) begin
    if (reset) begin
      px_reg     <= '0;
      py_reg     <= '0;
      x_reg      <= '0;
      y_reg      <= '0;
      colour_reg <= '0;
      plot_reg   <= 1'b0;
    end else if (load_pixel) begin
      px_reg     <= px_next;
      py_reg     <= py_next;
      x_reg      <= x_next;
      y_reg      <= y_next;
      colour_reg <= colour_next;
      plot_reg   <= 1'b1;
    end else begin
      plot_reg <= 1'b0;
    end
  end

  assign bus.busy_o   = busy_reg;
  assign bus.done_o   = done_reg;
  assign bus.ctrl_mem = ctrl_mem;
  assign bus.addr_out = ctrl_mem ? cell_addr : 7'd0;
  assign bus.data_out = 2'b00;
  assign bus.wren_o   = 1'b0;
  assign bus.x_o      = x_reg;
  assign bus.y_o      = y_reg;
  assign bus.colour_o = colour_reg;
  assign bus.plot_o   = plot_reg;

endmodule

// File: tb/tb_board_renderer.sv
// Directed bench for board_renderer: RD_LAT=2 main instance plus an RD_LAT=1 instance.
module tb_board_renderer;
  import othello_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  board_renderer_if b ();
  board_renderer_if b1 ();

  board_renderer #(.CELL_PX(8), .X0(48), .Y0(28), .RD_LAT(2)) dut (
    .clock (clock), .reset (reset), .bus (b)
  );
  board_renderer #(.CELL_PX(8), .X0(48), .Y0(28), .RD_LAT(1)) dut1 (
    .clock (clock), .reset (reset), .bus (b1)
  );

  // RAM model: registered read, plus an extra stage for the RD_LAT=2 path.
  logic [1:0] mem [0:127];
  logic [1:0] p0, p1, q1;
  always @(posedge clock) begin
    p0 <= mem[b.addr_out];
    p1 <= p0;
    q1 <= mem[b1.addr_out];
  end
  assign b.data_in  = p1;
  assign b1.data_in = q1;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Monitors sample on the falling edge.
  logic [2:0] fb  [0:19199];
  logic [2:0] fb1 [0:19199];
  int plot_cnt, done_cnt, done_cyc, busy_first, ctrl_run, ctrl_bad, wren_cnt, yellow_cnt;
  int plot_cnt1, done_cnt1, done_cyc1, busy_first1;
  int first_x, first_y;
  logic busy_prev = 1'b0, busy_prev1 = 1'b0;

  always @(negedge clock) begin
    if (b.plot_o) begin
      if (plot_cnt == 0) begin
        first_x = int'(b.x_o);
        first_y = int'(b.y_o);
      end
      fb[int'(b.y_o) * 160 + int'(b.x_o)] = b.colour_o;
      plot_cnt++;
      if (b.colour_o == 3'b110) yellow_cnt++;
    end
    if (b.done_o) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (b.busy_o && !busy_prev) busy_first = cyc;
    busy_prev = b.busy_o;
    if (b.wren_o) wren_cnt++;
    if (b.ctrl_mem) ctrl_run++;
    else begin
      if (ctrl_run != 0 && ctrl_run != 3) ctrl_bad++;
      ctrl_run = 0;
    end
  end

  always @(negedge clock) begin
    if (b1.plot_o) begin
      fb1[int'(b1.y_o) * 160 + int'(b1.x_o)] = b1.colour_o;
      plot_cnt1++;
    end
    if (b1.done_o) begin
      done_cnt1++;
      done_cyc1 = cyc;
    end
    if (b1.busy_o && !busy_prev1) busy_first1 = cyc;
    busy_prev1 = b1.busy_o;
  end

  function automatic logic [2:0] pix(input int x, input int y);
    return fb[y * 160 + x];
  endfunction

  function automatic logic [2:0] pix1(input int x, input int y);
    return fb1[y * 160 + x];
  endfunction

  task automatic clear_mon();
    for (int i = 0; i < 19200; i++) begin
      fb[i]  = 'x;
      fb1[i] = 'x;
    end
    plot_cnt = 0; done_cnt = 0; done_cyc = 0; busy_first = 0;
    ctrl_run = 0; ctrl_bad = 0; wren_cnt = 0; yellow_cnt = 0;
    plot_cnt1 = 0; done_cnt1 = 0; done_cyc1 = 0; busy_first1 = 0;
    first_x = -1; first_y = -1;
  endtask

  task automatic load_board();
    for (int i = 0; i < 128; i++) mem[i] = 2'b00;
    mem[44] = 2'b01; mem[55] = 2'b01;
    mem[45] = 2'b10; mem[54] = 2'b10;
  endtask

  task automatic pulse_start();
    @(posedge clock); #1 b.start = 1'b1;
    @(posedge clock); #1 b.start = 1'b0;
  endtask

  task automatic wait_done(output bit timeout);
    for (int i = 0; i < 6000 && done_cnt == 0; i++) @(posedge clock);
    timeout = (done_cnt == 0);
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    bit bad;
    reset = 1'b1; b.start = 1'b1; b1.start = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0; b.start = 1'b0; b1.start = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (b.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", b.busy_o); end
    checks++;
    if ({b.plot_o, b.ctrl_mem, b.done_o, b.wren_o} !== 4'b0000) begin
      errors++; $display("FAIL reset_strobes: got %b expected 0000", {b.plot_o, b.ctrl_mem, b.done_o, b.wren_o});
    end
    checks++;
    if ({b.x_o, b.y_o, b.colour_o, b.addr_out, b.data_out} !== 27'd0) begin
      errors++; $display("FAIL reset_buses: got x=%0d y=%0d c=%0d a=%0d expected all 0", b.x_o, b.y_o, b.colour_o, b.addr_out);
    end
    bad = (b1.busy_o !== 1'b0) || (b1.plot_o !== 1'b0);
    checks++;
    if (bad) begin errors++; $display("FAIL reset_rdlat1_idle: got busy=%b plot=%b expected 0 0", b1.busy_o, b1.plot_o); end
  endtask

  task automatic test_full_frame();
    bit to;
    load_board();
    b.cursor_addr = 7'd0;
    clear_mon();
    pulse_start();
    wait_done(to);
    checks++;
    if (to) begin errors++; $display("FAIL frame_timeout: got no done expected done"); end
    checks++;
    if (plot_cnt != 4096) begin errors++; $display("FAIL frame_plots: got %0d expected 4096", plot_cnt); end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL frame_done_count: got %0d expected 1", done_cnt); end
    checks++;
    if (done_cyc - busy_first != 4352) begin errors++; $display("FAIL frame_latency: got %0d expected 4352", done_cyc - busy_first); end
    checks++;
    if (pix(75, 55) !== 3'b000) begin errors++; $display("FAIL pix_p0: got %b expected 000", pix(75, 55)); end
    checks++;
    if (pix(83, 55) !== 3'b111) begin errors++; $display("FAIL pix_p1: got %b expected 111", pix(83, 55)); end
    checks++;
    if (pix(49, 29) !== 3'b010) begin errors++; $display("FAIL pix_empty: got %b expected 010", pix(49, 29)); end
    checks++;
    if (pix(48, 28) !== 3'b000) begin errors++; $display("FAIL pix_grid: got %b expected 000", pix(48, 28)); end
    checks++;
    if (yellow_cnt != 0) begin errors++; $display("FAIL no_cursor: got %0d yellow expected 0", yellow_cnt); end
    checks++;
    if (ctrl_bad != 0) begin errors++; $display("FAIL ctrl_mem_width: got %0d bad runs expected 0", ctrl_bad); end
    checks++;
    if (wren_cnt != 0) begin errors++; $display("FAIL wren: got %0d cycles high expected 0", wren_cnt); end
  endtask

  task automatic test_cursor();
    bit to;
    int bad_b, bad_i;
    logic [2:0] c;
    load_board();
    b.cursor_addr = 7'd11;
    clear_mon();
    pulse_start();
    wait_done(to);
    bad_b = 0; bad_i = 0;
    for (int py = 0; py < 8; py++) begin
      for (int px = 0; px < 8; px++) begin
        c = pix(48 + px, 28 + py);
        if (px == 0 || py == 0) begin
          if (c !== 3'b110) bad_b++;
        end else if (c !== 3'b010) bad_i++;
      end
    end
    checks++;
    if (to) begin errors++; $display("FAIL cursor_timeout: got no done expected done"); end
    checks++;
    if (bad_b != 0) begin errors++; $display("FAIL cursor_border: got %0d wrong pixels expected 0", bad_b); end
    checks++;
    if (bad_i != 0) begin errors++; $display("FAIL cursor_interior: got %0d wrong pixels expected 0", bad_i); end
    checks++;
    if (yellow_cnt != 15) begin errors++; $display("FAIL cursor_yellow_count: got %0d expected 15", yellow_cnt); end
    checks++;
    if (pix(56, 28) !== 3'b000) begin errors++; $display("FAIL cursor_neighbour: got %b expected 000", pix(56, 28)); end
    b.cursor_addr = 7'd0;
  endtask

  task automatic test_illegal_cell();
    bit to;
    load_board();
    mem[88] = 2'b11;
    clear_mon();
    pulse_start();
    wait_done(to);
    checks++;
    if (to) begin errors++; $display("FAIL illegal_timeout: got no done expected done"); end
    checks++;
    if (pix(107, 87) !== 3'b100) begin errors++; $display("FAIL illegal_interior: got %b expected 100", pix(107, 87)); end
    checks++;
    if (pix(104, 84) !== 3'b000) begin errors++; $display("FAIL illegal_border: got %b expected 000", pix(104, 84)); end
    checks++;
    if (ctrl_bad != 0 || wren_cnt != 0) begin
      errors++; $display("FAIL illegal_mem_ctrl: got bad=%0d wren=%0d expected 0 0", ctrl_bad, wren_cnt);
    end
    mem[88] = 2'b00;
  endtask

  task automatic test_back_to_back();
    bit to;
    load_board();
    clear_mon();
    pulse_start();
    repeat (98) @(posedge clock);
    pulse_start();
    wait_done(to);
    repeat (100) @(posedge clock);
    #1;
    checks++;
    if (to) begin errors++; $display("FAIL b2b_timeout: got no done expected done"); end
    checks++;
    if (plot_cnt != 4096) begin errors++; $display("FAIL b2b_plots: got %0d expected 4096", plot_cnt); end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL b2b_done_count: got %0d expected 1", done_cnt); end
    checks++;
    if (done_cyc - busy_first != 4352) begin errors++; $display("FAIL b2b_latency: got %0d expected 4352", done_cyc - busy_first); end
    checks++;
    if (b.busy_o !== 1'b0) begin errors++; $display("FAIL b2b_idle: got busy=%b expected 0", b.busy_o); end
  endtask

  task automatic test_reset_mid_frame();
    bit to;
    load_board();
    clear_mon();
    pulse_start();
    repeat (2000) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1;
    checks++;
    if ({b.plot_o, b.busy_o, b.ctrl_mem, b.done_o} !== 4'b0000) begin
      errors++; $display("FAIL midreset_outputs: got plot/busy/ctrl/done=%b expected 0000", {b.plot_o, b.busy_o, b.ctrl_mem, b.done_o});
    end
    reset = 1'b0;
    repeat (100) @(posedge clock);
    #1;
    checks++;
    if (done_cnt != 0) begin errors++; $display("FAIL midreset_no_done: got %0d expected 0", done_cnt); end
    clear_mon();
    pulse_start();
    wait_done(to);
    checks++;
    if (to || plot_cnt != 4096) begin errors++; $display("FAIL midreset_refresh: got plots=%0d timeout=%0d expected 4096 0", plot_cnt, to); end
    checks++;
    if (first_x != 48 || first_y != 28) begin errors++; $display("FAIL midreset_first_pixel: got (%0d,%0d) expected (48,28)", first_x, first_y); end
    checks++;
    if (pix(83, 55) !== 3'b111) begin errors++; $display("FAIL midreset_pix_p1: got %b expected 111", pix(83, 55)); end
  endtask

  task automatic test_rd_lat1();
    bit to;
    load_board();
    b1.cursor_addr = 7'd0;
    clear_mon();
    @(posedge clock); #1 b1.start = 1'b1;
    @(posedge clock); #1 b1.start = 1'b0;
    for (int i = 0; i < 6000 && done_cnt1 == 0; i++) @(posedge clock);
    to = (done_cnt1 == 0);
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (to) begin errors++; $display("FAIL lat1_timeout: got no done expected done"); end
    checks++;
    if (plot_cnt1 != 4096) begin errors++; $display("FAIL lat1_plots: got %0d expected 4096", plot_cnt1); end
    checks++;
    if (done_cyc1 - busy_first1 != 4288) begin errors++; $display("FAIL lat1_latency: got %0d expected 4288", done_cyc1 - busy_first1); end
    checks++;
    if (pix1(75, 55) !== 3'b000) begin errors++; $display("FAIL lat1_pix_p0: got %b expected 000", pix1(75, 55)); end
    checks++;
    if (pix1(83, 55) !== 3'b111) begin errors++; $display("FAIL lat1_pix_p1: got %b expected 111", pix1(83, 55)); end
    checks++;
    if (pix1(49, 29) !== 3'b010) begin errors++; $display("FAIL lat1_pix_empty: got %b expected 010", pix1(49, 29)); end
  endtask

  initial begin
    reset = 1'b1;
    b.start = 1'b0;  b.cursor_addr = 7'd0;
    b1.start = 1'b0; b1.cursor_addr = 7'd0;
    for (int i = 0; i < 128; i++) mem[i] = 2'b00;
    clear_mon();
    test_reset();
    $display("test_reset done: checks=%0d errors=%0d", checks, errors);
    test_full_frame();
    $display("test_full_frame done: checks=%0d errors=%0d", checks, errors);
    test_cursor();
    $display("test_cursor done: checks=%0d errors=%0d", checks, errors);
    test_illegal_cell();
    $display("test_illegal_cell done: checks=%0d errors=%0d", checks, errors);
    test_back_to_back();
    $display("test_back_to_back done: checks=%0d errors=%0d", checks, errors);
    test_reset_mid_frame();
    $display("test_reset_mid_frame done: checks=%0d errors=%0d", checks, errors);
    test_rd_lat1();
    $display("test_rd_lat1 done: checks=%0d errors=%0d", checks, errors);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
